// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs and stall/flush/counter outputs
// between the pipeline (master) and the hazard controller (slave).
interface pipe_ctrl_if #(
  parameter int NSTAGES = 5,
  parameter int CNT_W   = 64
);
  logic               id_branch_flush_i;
  logic               id_load_use_i;
  logic               id_fence_i;
  logic               ex_busy_i;
  logic               mem_busy_i;
  logic               wb_exception_i;
  logic               wb_retire_i;
  logic [NSTAGES-1:0] stall_o;
  logic [NSTAGES-1:0] flush_o;
  logic               fence_busy_o;
  logic [CNT_W-1:0]   nr_insts_o;
  logic [CNT_W-1:0]   nr_cycles_o;

  modport master (
    output id_branch_flush_i,
    output id_load_use_i,
    output id_fence_i,
    output ex_busy_i,
    output mem_busy_i,
    output wb_exception_i,
    output wb_retire_i,
    input  stall_o,
    input  flush_o,
    input  fence_busy_o,
    input  nr_insts_o,
    input  nr_cycles_o
  );

  modport slave (
    input  id_branch_flush_i,
    input  id_load_use_i,
    input  id_fence_i,
    input  ex_busy_i,
    input  mem_busy_i,
    input  wb_exception_i,
    input  wb_retire_i,
    output stall_o,
    output flush_o,
    output fence_busy_o,
    output nr_insts_o,
    output nr_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: priority stall/flush resolution, fence drain FSM,
// retire and cycle counters for a generic-depth in-order pipe.
module pipe_ctrl #(
  parameter int NSTAGES = 5,
  parameter int EX_IDX  = 2,
  parameter int MEM_IDX = 3,
  parameter int CNT_W   = 64
) (
  input logic        clock,
  input logic        reset,
  pipe_ctrl_if.slave bus
);
  localparam int DCW = $clog2(NSTAGES);
  localparam logic [NSTAGES-1:0] ONE = NSTAGES'(1);
  localparam logic [NSTAGES-1:0] ALL = '1;
  localparam logic [NSTAGES-1:0] MEM_ST =
    ALL >> (NSTAGES - 1 - MEM_IDX);
  localparam logic [NSTAGES-1:0] MEM_FL = ONE << (MEM_IDX + 1);
  localparam logic [NSTAGES-1:0] EX_ST =
    ALL >> (NSTAGES - 1 - EX_IDX);
  localparam logic [NSTAGES-1:0] EX_FL = ONE << (EX_IDX + 1);
  localparam logic [NSTAGES-1:0] ID_ST = ALL >> (NSTAGES - 2);
  localparam logic [NSTAGES-1:0] ID_FL = ONE << 2;
  localparam logic [NSTAGES-1:0] BR_FL = ONE << 1;
  localparam logic [DCW-1:0] DC_INIT = DCW'(NSTAGES - 3);

  typedef enum logic [1:0] {IDLE, DRAIN, PASS} state_t;

  state_t             state;
  logic [DCW-1:0]     dc;
  logic [CNT_W-1:0]   nr_insts;
  logic [CNT_W-1:0]   nr_cycles;
  logic [NSTAGES-1:0] stall;
  logic [NSTAGES-1:0] flush;
  logic pause;
  logic fence_stall;
  logic ev_exc, ev_mem, ev_ex, ev_id, ev_br;

  // pause covers every event that outranks the ID-level stall
  assign pause = bus.wb_exception_i | bus.mem_busy_i
               | bus.ex_busy_i;
  assign fence_stall = (state == DRAIN)
    | ((state == IDLE) & bus.id_fence_i & ~pause);

  assign ev_exc = ~reset & bus.wb_exception_i;
  assign ev_mem = ~reset & ~bus.wb_exception_i
                & bus.mem_busy_i;
  assign ev_ex  = ~reset & ~bus.wb_exception_i
                & ~bus.mem_busy_i & bus.ex_busy_i;
  assign ev_id  = ~reset & ~pause
                & (bus.id_load_use_i | fence_stall);
  assign ev_br  = ~reset & ~pause & ~bus.id_load_use_i
                & ~fence_stall & bus.id_branch_flush_i;

  always_comb begin
    stall = '0;
    flush = '0;
    unique case (1'b1)
      reset, ev_exc: flush = ALL;
      ev_mem: begin
        stall = MEM_ST;
        flush = MEM_FL;
      end
      ev_ex: begin
        stall = EX_ST;
        flush = EX_FL;
      end
      ev_id: begin
        stall = ID_ST;
        flush = ID_FL;
      end
      ev_br:   flush = BR_FL;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      dc    <= '0;
    end else if (bus.wb_exception_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (bus.id_fence_i && !pause) begin
          dc    <= DC_INIT;
          state <= (DC_INIT == '0) ? PASS : DRAIN;
        end
        DRAIN: if (!pause) begin
          dc <= dc - 1'b1;
          if (dc == DCW'(1)) state <= PASS;
        end
        PASS:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      nr_insts  <= '0;
      nr_cycles <= '0;
    end else begin
      nr_cycles <= nr_cycles + 1'b1;
      if (bus.wb_retire_i && !bus.wb_exception_i)
        nr_insts <= nr_insts + 1'b1;
    end
  end

  assign bus.stall_o      = stall;
  assign bus.flush_o      = flush;
  assign bus.fence_busy_o = ~reset & (state != IDLE);
  assign bus.nr_insts_o   = nr_insts;
  assign bus.nr_cycles_o  = nr_cycles;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: two configurations against a cycle-level model,
// expectations queued by the driver and popped by the monitor.
module tb_pipe_ctrl;
  localparam logic [7:0] R  = 8'h80;
  localparam logic [7:0] BR = 8'h40;
  localparam logic [7:0] LU = 8'h20;
  localparam logic [7:0] FE = 8'h10;
  localparam logic [7:0] EX = 8'h08;
  localparam logic [7:0] ME = 8'h04;
  localparam logic [7:0] XC = 8'h02;
  localparam logic [7:0] RT = 8'h01;

  localparam int NS [2] = '{5, 6};
  localparam int EI [2] = '{2, 2};
  localparam int MI [2] = '{3, 4};
  localparam int CW [2] = '{64, 4};

  typedef struct packed {
    logic [7:0]  stall;
    logic [7:0]  flush;
    logic        busy;
    logic [63:0] insts;
    logic [63:0] cycles;
    logic        ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.NSTAGES(5), .CNT_W(64)) a_if ();
  pipe_ctrl_if #(.NSTAGES(6), .CNT_W(4))  b_if ();

  pipe_ctrl #(
    .NSTAGES(5), .EX_IDX(2), .MEM_IDX(3), .CNT_W(64)
  ) u_a (.clock(clk), .reset(rst), .bus(a_if));

  pipe_ctrl #(
    .NSTAGES(6), .EX_IDX(2), .MEM_IDX(4), .CNT_W(4)
  ) u_b (.clock(clk), .reset(rst), .bus(b_if));

  exp_t qa[$];
  exp_t qb[$];
  int n_pass = 0;
  int n_total = 0;

  // model: fence = remaining unpaused stall cycles + pass flag
  int          rem   [2] = '{0, 0};
  bit          pass  [2] = '{0, 0};
  logic [63:0] ins   [2];
  logic [63:0] cyc   [2];
  bit          known [2] = '{0, 0};

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  function automatic exp_t model(int k, logic [7:0] s);
    exp_t e;
    logic [63:0] m;
    logic [7:0] all;
    bit xc, p13, fst;
    m = (CW[k] == 64) ? '1 : ((64'd1 << CW[k]) - 64'd1);
    all = 8'((16'd1 << NS[k]) - 16'd1);
    e = '0;
    e.insts  = ins[k];
    e.cycles = cyc[k];
    e.ok     = known[k];
    if (s[7]) begin
      e.flush  = all;
      rem[k]   = 0;
      pass[k]  = 0;
      ins[k]   = '0;
      cyc[k]   = '0;
      known[k] = 1;
      return e;
    end
    xc  = s[1];
    p13 = s[1] | s[2] | s[3];
    fst = (rem[k] > 0) || (!pass[k] && s[4] && !p13);
    e.busy = (rem[k] > 0) || pass[k];
    if (xc) e.flush = all;
    else if (s[2]) begin
      e.stall = 8'((16'd1 << (MI[k] + 1)) - 16'd1);
      e.flush = 8'(16'd1 << (MI[k] + 1));
    end else if (s[3]) begin
      e.stall = 8'((16'd1 << (EI[k] + 1)) - 16'd1);
      e.flush = 8'(16'd1 << (EI[k] + 1));
    end else if (s[5] || fst) begin
      e.stall = 8'd3;
      e.flush = 8'd4;
    end else if (s[6]) e.flush = 8'd2;
    if (xc) begin
      rem[k]  = 0;
      pass[k] = 0;
    end else if (pass[k]) pass[k] = 0;
    else if (rem[k] > 0) begin
      if (!p13) begin
        rem[k]--;
        if (rem[k] == 0) pass[k] = 1;
      end
    end else if (s[4] && !p13) begin
      // entry cycle already counts as one of NSTAGES-2
      rem[k] = NS[k] - 3;
      if (rem[k] == 0) pass[k] = 1;
    end
    if (s[0] && !xc) ins[k] = (ins[k] + 64'd1) & m;
    cyc[k] = (cyc[k] + 64'd1) & m;
    return e;
  endfunction

  task automatic apply(logic [7:0] s);
    rst = s[7];
    a_if.id_branch_flush_i = s[6];
    a_if.id_load_use_i     = s[5];
    a_if.id_fence_i        = s[4];
    a_if.ex_busy_i         = s[3];
    a_if.mem_busy_i        = s[2];
    a_if.wb_exception_i    = s[1];
    a_if.wb_retire_i       = s[0];
    b_if.id_branch_flush_i = s[6];
    b_if.id_load_use_i     = s[5];
    b_if.id_fence_i        = s[4];
    b_if.ex_busy_i         = s[3];
    b_if.mem_busy_i        = s[2];
    b_if.wb_exception_i    = s[1];
    b_if.wb_retire_i       = s[0];
  endtask

  task automatic drive(logic [7:0] s);
    @(posedge clk);
    #1;
    apply(s);
    qa.push_back(model(0, s));
    qb.push_back(model(1, s));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_stall", 64'(a_if.stall_o), 64'(e.stall));
        chk("a_flush", 64'(a_if.flush_o), 64'(e.flush));
        chk("a_busy", 64'(a_if.fence_busy_o), 64'(e.busy));
        if (e.ok) begin
          chk("a_insts", a_if.nr_insts_o, e.insts);
          chk("a_cycles", a_if.nr_cycles_o, e.cycles);
        end
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_stall", 64'(b_if.stall_o), 64'(e.stall));
        chk("b_flush", 64'(b_if.flush_o), 64'(e.flush));
        chk("b_busy", 64'(b_if.fence_busy_o), 64'(e.busy));
        if (e.ok) begin
          chk("b_insts", 64'(b_if.nr_insts_o), e.insts);
          chk("b_cycles", 64'(b_if.nr_cycles_o), e.cycles);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] s;
    apply(R);
    drive(R);
    drive(R);
    repeat (10) drive(RT);
    drive(8'h00);
    @(negedge clk);
    chk("idle_insts", a_if.nr_insts_o, 64'd10);
    chk("idle_cycles", a_if.nr_cycles_o, 64'd10);
    drive(EX);
    drive(EX | ME);
    drive(EX);
    drive(EX);
    drive(8'h00);
    repeat (5) drive(FE);
    repeat (3) drive(8'h00);
    drive(FE);
    drive(FE | EX);
    repeat (3) drive(FE);
    repeat (2) drive(8'h00);
    drive(FE);
    drive(FE);
    drive(XC | BR | RT);
    drive(8'h00);
    @(negedge clk);
    chk("exc_busy", 64'(a_if.fence_busy_o), 64'd0);
    drive(FE);
    drive(FE | R);
    drive(8'h00);
    drive(LU | BR);
    drive(BR);
    drive(8'h00);
    repeat (17) drive(RT);
    drive(ME);
    repeat (6) drive(FE);
    for (int i = 0; i < 3000; i++) begin
      s = 8'h00;
      if ($urandom_range(199) == 0) s |= R;
      if ($urandom_range(29) == 0)  s |= XC;
      if ($urandom_range(7) == 0)   s |= ME;
      if ($urandom_range(7) == 0)   s |= EX;
      if ($urandom_range(5) == 0)   s |= FE;
      if ($urandom_range(7) == 0)   s |= LU;
      if ($urandom_range(4) == 0)   s |= BR;
      if ($urandom_range(1) == 0)   s |= RT;
      drive(s);
    end
    drive(8'h00);
    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(qa.size() + qb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
